abc_sweep_capture: RTL
======================

ABC_SWEEP_CAPTURE -- requirements
Module: abc_sweep_capture

Interface
REQ-001 The block SHALL be clocked by one clock and use a synchronous, active-high reset.
REQ-002 Parameter: SETTLE_CYCLES, default 2, number of cycles each input vector is held before sampling; legal range 1..15.
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  single-cycle request to begin a sweep.
REQ-006 Port: ack  input  1  consumer acknowledge of completed results.
REQ-007 Port: x_in, y_in  input  1 each  outputs of the downstream combinational stage under test.
REQ-008 Port: a, b, c  output  1 each  registered stimulus to the combinational stage.
REQ-009 Port: busy  output  1  high while a sweep is in progress.
REQ-010 Port: done  output  1  high while results are complete and unacknowledged.
REQ-011 Port: results  output  16  captured table; bit 2i = x, bit 2i+1 = y for vector index i.
REQ-012 Port: mismatch_cnt  output  4  number of vectors differing from golden model (present only with macro).

Function
REQ-013 FSM states SHALL be IDLE, SETTLE, CAPTURE, DONE.
REQ-014 Vector index i (3 bits) SHALL drive a=i[2], b=i[1], c=i[0] from registers.
REQ-015 IDLE: start=1 SHALL clear results and mismatch_cnt, set i=0, load settle counter, enter SETTLE.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then enter CAPTURE.
REQ-017 CAPTURE SHALL write {y_in,x_in} into results[2i+1:2i] for exactly one cycle.
REQ-018 After CAPTURE: i<7 -> increment i, reload counter, enter SETTLE; i=7 -> enter DONE, i held at 7.
REQ-019 done SHALL rise 8*(SETTLE_CYCLES+1)+1 cycles after the edge sampling start (25 for default).
REQ-020 DONE: results held stable; ack=1 -> IDLE next cycle, done low.
REQ-021 start SHALL be ignored in SETTLE, CAPTURE, DONE; start and ack together in DONE -> ack wins, no new sweep.
REQ-022 ack SHALL be ignored outside DONE.
REQ-023 busy SHALL equal (state is SETTLE or CAPTURE); busy and done never both high.
REQ-024 results SHALL only change in CAPTURE or on sweep start/reset; no partial update visible in DONE.

Reset
REQ-025 reset SHALL force IDLE, i=0, a=b=c=0, busy=0, done=0, results=16'h0000, mismatch_cnt=0, counter=0.
REQ-026 reset asserted mid-sweep SHALL abandon the sweep with no result retained; reset has priority over start/ack.

Configuration
REQ-027 Macro SWEEP_SELFCHECK_EN defined: golden model x=~c^(a|b), y=a&b evaluated in CAPTURE; each differing vector increments mismatch_cnt (saturates at 8, 4-bit).
REQ-028 Macro undefined: no golden model, mismatch_cnt port absent, all other behaviour identical.

Structure
REQ-029 Shared package sweep_pkg SHALL hold the state enum, NUM_VECTORS=8, RESULT_W=16, and the default SETTLE_CYCLES constant.
REQ-030 Golden model SHALL be sub-module sweep_golden (pure combinational, 3 in, 2 out), instantiated only under SWEEP_SELFCHECK_EN.
REQ-031 Bench SHALL connect the team combinational stage between a/b/c and x_in/y_in.

Verification
REQ-032 Reset, start pulse, correct stage connected, default params -> done at cycle 25, results=16'hE441, mismatch_cnt=0.
REQ-033 y_in forced 0 for whole sweep (macro on) -> results=16'h4441, mismatch_cnt=2.
REQ-034 start pulsed again at cycle 10 of sweep -> ignored, done still at cycle 25, results=16'hE441.
REQ-035 reset asserted at cycle 12 -> next cycle busy=0, results=0, a=b=c=0; fresh start completes normally.
REQ-036 start and ack asserted together in DONE -> IDLE, done=0, busy=0; no sweep begins.
REQ-037 SETTLE_CYCLES=1 -> done at cycle 17, a/b/c step every 2 cycles 000..111.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared definitions for the a/b/c sweep-and-capture block: FSM state
// encoding, table geometry and the default settle time.
package sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } sweep_state_e;

    localparam int NUM_VECTORS       = 8;
    localparam int RESULT_W          = 16;
    localparam int SETTLE_CYCLES_DEF = 2;

endpackage

// File: rtl/sweep_golden.sv
// Golden model of the combinational stage under test: x = ~c ^ (a | b),
// y = a & b. Only compiled when SWEEP_SELFCHECK_EN is defined, since the
// sweep block instantiates it only in that build.
`ifdef SWEEP_SELFCHECK_EN
module sweep_golden (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic x,
    output logic y
);

    // pure combinational reference of the stage
    always_comb begin
        x = ~c ^ (a | b);
        y = a & b;
    end

endmodule
`endif

// File: rtl/abc_sweep_capture.sv
// abc_sweep_capture: steps a 3-bit vector through all 8 codes on a/b/c,
// waits SETTLE_CYCLES for the combinational stage to settle, captures
// {y_in,x_in} per vector into a 16-bit table and raises done.
// Optional feature macro: SWEEP_SELFCHECK_EN adds a golden-model compare
// and the mismatch_cnt output.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | waiting for start; results hold last table
// ST_SETTLE  | vector applied, counting down settle time
// ST_CAPTURE | one cycle: write {y_in,x_in} for current vector
// ST_DONE    | table complete, waiting for ack
//
// done is a registered flag set one cycle after entering ST_DONE, so a
// completed sweep reports 8*(SETTLE_CYCLES+1)+1 cycles after start.
module abc_sweep_capture
    import sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                ack,
    input  logic                x_in,
    input  logic                y_in,
    output logic                a,
    output logic                b,
    output logic                c,
    output logic                busy,
    output logic                done,
    output logic [RESULT_W-1:0] results
`ifdef SWEEP_SELFCHECK_EN
    ,
    output logic [3:0]          mismatch_cnt
`endif
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    sweep_state_e          state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [RESULT_W-1:0]   results_q, results_d;
    logic                  done_q, done_d;

`ifdef SWEEP_SELFCHECK_EN
    logic [3:0]            mis_q, mis_d;
    logic                  gold_x, gold_y;

    sweep_golden u_golden (
        .a (idx_q[2]),
        .b (idx_q[1]),
        .c (idx_q[0]),
        .x (gold_x),
        .y (gold_y)
    );
`endif

    // next-state, vector index, settle timer and capture logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        results_d = results_q;
        done_d    = 1'b0;
`ifdef SWEEP_SELFCHECK_EN
        mis_d     = mis_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    results_d = '0;
                    idx_d     = 3'd0;
                    cnt_d     = SETTLE_LOAD;
                    state_d   = ST_SETTLE;
`ifdef SWEEP_SELFCHECK_EN
                    mis_d     = 4'd0;
`endif
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CAPTURE: begin
                results_d[{idx_q, 1'b0} +: 2] = {y_in, x_in};
`ifdef SWEEP_SELFCHECK_EN
                if (((x_in != gold_x) || (y_in != gold_y)) && (mis_q != 4'd8)) begin
                    mis_d = mis_q + 4'd1;
                end
`endif
                if (idx_q == 3'd7) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = SETTLE_LOAD;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                // ack has priority; start is ignored here
                if (ack) begin
                    state_d = ST_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            cnt_q     <= 4'd0;
            results_q <= '0;
            done_q    <= 1'b0;
`ifdef SWEEP_SELFCHECK_EN
            mis_q     <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            results_q <= results_d;
            done_q    <= done_d;
`ifdef SWEEP_SELFCHECK_EN
            mis_q     <= mis_d;
`endif
        end
    end

    // outputs come straight from registers
    always_comb begin
        a       = idx_q[2];
        b       = idx_q[1];
        c       = idx_q[0];
        busy    = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
        done    = done_q;
        results = results_q;
`ifdef SWEEP_SELFCHECK_EN
        mismatch_cnt = mis_q;
`endif
    end

endmodule
